// File: rtl/bsr_chain.sv
// Boundary-scan register chain: a capture/shift stage feeding an update
// latch stage, with a test-mode mux between the core-side inputs and the pads.
// Several of these are instantiated side by side, one per scan chain, and
// each serial output goes to the chain-select mux on the TDO path.
module bsr_chain #(
  parameter int unsigned           LENGTH    = 8,
  parameter logic [LENGTH-1:0]     RESET_VAL = '0
) (
  input  logic              tck,
  input  logic              rst,
  input  logic              chain_en,
  input  logic              tdi,
  input  logic              capture_dr,
  input  logic              shift_dr,
  input  logic              update_dr,
  input  logic              mode,
  input  logic [LENGTH-1:0] pi,
  output logic [LENGTH-1:0] po,
  output logic              bsr_so
);

  logic [LENGTH-1:0] sreg_q;
  logic [LENGTH-1:0] sreg_d;
  logic [LENGTH-1:0] ureg_q;
  logic [LENGTH-1:0] ureg_d;
  logic [LENGTH-1:0] shifted;

  // Serial data enters at the top cell and moves toward cell 0; a one-cell
  // chain simply takes tdi.
  if (LENGTH == 1) begin : g_single
    assign shifted = tdi;
  end else begin : g_multi
    assign shifted = {tdi, sreg_q[LENGTH-1:1]};
  end

  // Next-state selection: capture beats shift, and update copies the shift
  // stage as it stood before this edge, so a shift and an update on the same
  // edge load the pre-shift value into the latches.
  always_comb begin
    sreg_d = sreg_q;
    ureg_d = ureg_q;
    if (chain_en) begin
      if (capture_dr) begin
        sreg_d = pi;
      end else if (shift_dr) begin
        sreg_d = shifted;
      end
      if (update_dr) begin
        ureg_d = sreg_q;
      end
    end
  end

  // State registers; reset wins over every strobe and drops any partial shift.
  always_ff @(posedge tck) begin
    if (rst) begin
      sreg_q <= '0;
      ureg_q <= RESET_VAL;
    end else begin
      sreg_q <= sreg_d;
      ureg_q <= ureg_d;
    end
  end

  // Cell 0 is the serial output; mode switches the pads between the update
  // latches and plain pass-through without touching either stage.
  assign bsr_so = sreg_q[0];
  assign po     = mode ? ureg_q : pi;

endmodule

// File: tb/tb_bsr_chain.sv
// Testbench for bsr_chain: a four-cell chain and a one-cell chain share the
// TAP strobes; a reference model predicts pads and serial output after every
// edge, and a monitor compares them against the DUTs.
module tb_bsr_chain;

  logic       tck;
  logic       rst;
  logic       chainEn;
  logic       tdi;
  logic       captureDr;
  logic       shiftDr;
  logic       updateDr;
  logic       mode;
  logic [3:0] pi4;
  logic [3:0] po4;
  logic       so4;
  logic [0:0] pi1;
  logic [0:0] po1;
  logic       so1;

  int checks;
  int failures;

  typedef struct {
    int po4;
    int so4;
    int po1;
    int so1;
  } exp_t;

  exp_t expQ[$];

  // Reference state of each chain, held as plain integers.
  int s4;
  int u4;
  int s1;
  int u1;

  localparam int RV4 = 'b1010;
  localparam int RV1 = 0;

  bsr_chain #(.LENGTH(4), .RESET_VAL(4'b1010)) dut4 (
    .tck(tck), .rst(rst), .chain_en(chainEn), .tdi(tdi),
    .capture_dr(captureDr), .shift_dr(shiftDr), .update_dr(updateDr),
    .mode(mode), .pi(pi4), .po(po4), .bsr_so(so4)
  );

  bsr_chain #(.LENGTH(1), .RESET_VAL(1'b0)) dut1 (
    .tck(tck), .rst(rst), .chain_en(chainEn), .tdi(tdi),
    .capture_dr(captureDr), .shift_dr(shiftDr), .update_dr(updateDr),
    .mode(mode), .pi(pi1), .po(po1), .bsr_so(so1)
  );

  // Free-running test clock.
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  // Compare one observed value against its prediction.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one chain of length len through one rising edge.
  function automatic void modelStep(input int len, input int rv, input int piV,
                                    input bit r, input bit en, input bit cap,
                                    input bit sh, input bit upd, input bit din,
                                    inout int s, inout int u);
    int oldS;
    oldS = s;
    if (r) begin
      s = 0;
      u = rv;
    end else if (en) begin
      if (cap)     s = piV;
      else if (sh) s = (oldS / 2) + (din ? (1 << (len - 1)) : 0);
      if (upd)     u = oldS;
    end
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input bit r, input bit en, input bit cap,
                               input bit sh, input bit upd, input bit din,
                               input bit md, input int p4, input int p1);
    exp_t e;
    @(negedge tck);
    rst = r; chainEn = en; captureDr = cap; shiftDr = sh; updateDr = upd;
    tdi = din; mode = md; pi4 = p4[3:0]; pi1 = p1[0:0];
    modelStep(4, RV4, p4, r, en, cap, sh, upd, din, s4, u4);
    modelStep(1, RV1, p1, r, en, cap, sh, upd, din, s1, u1);
    e.po4 = md ? u4 : p4;
    e.so4 = s4 % 2;
    e.po1 = md ? u1 : p1;
    e.so1 = s1 % 2;
    expQ.push_back(e);
  endtask

  // Monitor: after every rising edge, pop the prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge tck);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("po4", int'(po4), e.po4);
        checkOutput("so4", int'(so4), e.so4);
        checkOutput("po1", int'(po1), e.po1);
        checkOutput("so1", int'(so1), e.so1);
      end
    end
  end

  // Directed scenarios first, then randomized traffic, then drain and report.
  initial begin
    int wait_cycles;
    checks = 0; failures = 0;
    s4 = 0; u4 = 0; s1 = 0; u1 = 0;
    rst = 1'b1; chainEn = 1'b0; tdi = 1'b0; captureDr = 1'b0;
    shiftDr = 1'b0; updateDr = 1'b0; mode = 1'b1; pi4 = 4'b0110; pi1 = 1'b0;

    // Reset in test mode, then pass-through view.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 'b0110, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 'b0110, 1);

    // Capture 1101 then shift out with tdi=0.
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 'b1101, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, 0, 0, 0, 'b1101, 0);

    // Shift in 1,0,0,1 then update in test mode.
    applyStimulus(0, 1, 0, 1, 0, 1, 1, 'b0000, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 1, 'b0000, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 1, 'b0000, 0);
    applyStimulus(0, 1, 0, 1, 0, 1, 1, 'b0000, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 'b0000, 0);

    // Capture and shift together, observed through an update.
    applyStimulus(0, 1, 1, 1, 0, 1, 1, 'b0011, 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 'b0011, 1);

    // Load 1111, then shift and update together, then update again.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, 0, 1, 1, 'b0000, 0);
    applyStimulus(0, 1, 0, 1, 1, 0, 1, 'b0000, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 'b0000, 0);

    // Deselected chain ignores everything.
    applyStimulus(0, 0, 1, 0, 0, 1, 1, 'b1100, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 1, 1, 'b1100, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 'b1100, 1);

    // Reset after two of four shifts, then try to update the discarded data.
    applyStimulus(0, 1, 0, 1, 0, 1, 1, 'b0000, 0);
    applyStimulus(0, 1, 0, 1, 0, 1, 1, 'b0000, 0);
    applyStimulus(1, 1, 0, 1, 0, 1, 1, 'b0000, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 'b0000, 0);

    // Randomized traffic with occasional resets and mode flips.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 24) == 0), ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 1));
    end

    // Let the monitor consume the last prediction, bounded.
    wait_cycles = 0;
    while (expQ.size() > 0 && wait_cycles < 10) begin
      @(posedge tck);
      #2;
      wait_cycles++;
    end
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
